jtdsp16_rom_fetch: RTL and testbench
====================================

// Module: jtdsp16_rom_fetch
// PURPOSE
// Program-memory fetch stage between the XAAU (rom_addr source) and the ROM data consumers (rom_dout sink).
// Routes each fetch to internal ROM (zero stall) or to external program memory over a req/ok handshake.
// Keeps a one-word hit register so a repeated external address (pc_halt, 1-word do loop) does not re-request.
// Gates the core clock enable (cpu_cen) while an external fetch is outstanding; counts stall cycles for debug.
// PARAMETERS
// INT_AW  12  internal ROM address bits; internal window = 0 .. 2**INT_AW-1
// SCW     16  width of saturating stall counter
// PORTS
// rst        in   1       asynchronous reset, active-high
// clk        in   1       clock
// cen        in   1       system clock enable
// ext_mode   in   1       EXM: 1 = every fetch goes external
// rom_addr   in   16      fetch address from XAAU (its pc)
// int_addr   out  INT_AW  internal ROM address = rom_addr[INT_AW-1:0], combinational
// int_dout   in   16      internal ROM data, valid same cycle as int_addr
// ext_addr   out  16      external fetch address, registered
// ext_req    out  1       external request, level, held until ext_ok
// ext_ok     in   1       external data valid (single-cycle pulse)
// ext_data   in   16      external data, sampled when ext_ok=1
// rom_dout   out  16      instruction word to XAAU/decoder
// cpu_cen    out  1       gated enable for XAAU/core
// fetch_busy out  1       1 while state==WAIT
// stall_cnt  out  SCW     cycles with cen=1 && cpu_cen=0, saturates at all-ones
// BEHAVIOUR
// - Reset: state=IDLE, ext_req=0, ext_addr=0, hit_addr=0, hit_data=0, hit_vld=0, stall_cnt=0, last_exm=0.
//   cpu_cen then equals cen, except when rom_addr is external (miss, hit_vld=0), where it is 0.
// - ext_sel = ext_mode || (rom_addr[15:INT_AW] != 0).
// - hit = hit_vld && (hit_addr == rom_addr).
// - miss = ext_sel && !hit.
// - rom_dout = ext_sel ? hit_data : int_dout.
//   Combinational; only meaningful when cpu_cen=1.
// - cpu_cen = cen && state==IDLE && !miss (combinational).
// - All register updates below occur only when cen=1. ext_ok arriving while cen=0 is lost (external side holds ok until a cen cycle).
// - FSM IDLE:
//   - miss: ext_addr<=rom_addr, ext_req<=1, ->WAIT.
//   - otherwise: stay.
// - FSM WAIT (ext_req=1, cpu_cen=0):
//   - ext_ok=1: hit_data<=ext_data, hit_addr<=ext_addr, hit_vld<=1, ext_req<=0, ->IDLE.
//   - otherwise: hold, no timeout.
// - ext_ok while IDLE: ignored.
// - Miss penalty: miss seen at cycle N; first cycle with ext_ok=1 is M (>=N+1).
//   - Hit valid at M+1; cpu_cen=1 at M+1.
//   - Stall = M+1-N cen cycles; minimum 2 (ok at N+1).
// - Internal fetch: never stalls, never touches hit register.
// - ext_mode change: last_exm<=ext_mode each cen. If ext_mode!=last_exm, clear hit_vld.
//   - In WAIT the clear is applied after completion: the new word is stored, but hit_vld=0.
//   - This forces a refetch.
// - rom_addr is stable during WAIT because XAAU is frozen by cpu_cen; no abort path.
// - stall_cnt increments when cen && !cpu_cen; holds at 2**SCW-1.
// - Reset mid-transaction: ext_req drops asynchronously; a late ext_ok after reset is ignored (IDLE).
// TESTING
// 1. ext_mode=0, rom_addr 0x0000..0x0FFF sequential, cen=1 always -> cpu_cen=1 every cycle, rom_dout=int_dout, ext_req never 1.
// 2. rom_addr=0x1234 (external), ext_ok 3 cycles after req -> ext_addr=0x1234, ext_req high 3 cycles,
//    cpu_cen low 4 cycles, rom_dout=ext_data, stall_cnt=4.
// 3. Same 0x1234 held 5 cycles after fill (pc_halt) -> single request only; cpu_cen=1 all 5 cycles.
// 4. Toggle ext_mode 0->1 with rom_addr=0x0010 -> external request issued for 0x0010; ext_mode 1->0 after fill -> int_dout used.
// 5. Assert rst while ext_req=1, then pulse ext_ok -> ext_req=0 immediately, state IDLE, hit_vld=0, no capture.
// 6. cen=0 for 2 of every 3 cycles during a miss -> handshake progresses only on cen cycles, stall_cnt counts cen cycles only.

Source files
------------

// File: rtl/jtdsp16_rom_fetch_if.sv
// External program-memory fetch bus: registered address/request out, data/ok back.
// The master side is the fetch stage; the slave side is the external memory controller.
interface jtdsp16_rom_fetch_if;
    logic [15:0] ext_addr;
    logic        ext_req;
    logic        ext_ok;
    logic [15:0] ext_data;

    modport master (
        output ext_addr,
        output ext_req,
        input  ext_ok,
        input  ext_data
    );

    modport slave (
        input  ext_addr,
        input  ext_req,
        output ext_ok,
        output ext_data
    );
endinterface

// File: rtl/jtdsp16_rom_fetch.sv
// Program-memory fetch stage: routes fetches to internal ROM or to external memory,
// caches the last external word, gates the core enable and counts stall cycles.
module jtdsp16_rom_fetch #(
    parameter int unsigned INT_AW = 12,
    parameter int unsigned SCW    = 16
) (
    input  logic              rst,
    input  logic              clk,
    input  logic              cen,
    input  logic              ext_mode,
    input  logic [15:0]       rom_addr,
    output logic [INT_AW-1:0] int_addr,
    input  logic [15:0]       int_dout,
    jtdsp16_rom_fetch_if.master ext,
    output logic [15:0]       rom_dout,
    output logic              cpu_cen,
    output logic              fetch_busy,
    output logic [SCW-1:0]    stall_cnt
);

    localparam logic [SCW-1:0] STALL_MAX = {SCW{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t      state;
    logic [15:0] hit_addr;
    logic [15:0] hit_data;
    logic        hit_vld;
    logic        last_exm;

    logic        ext_sel;
    logic        hit;
    logic        miss;
    logic        exm_chg;

    assign int_addr = rom_addr[INT_AW-1:0];

    // Address decode, hit detection and the core enable gate.
    always_comb begin
        ext_sel    = ext_mode || ((rom_addr >> INT_AW) != 16'd0);
        hit        = hit_vld && (hit_addr == rom_addr);
        miss       = ext_sel && !hit;
        exm_chg    = ext_mode != last_exm;
        rom_dout   = ext_sel ? hit_data : int_dout;
        cpu_cen    = cen && (state == IDLE) && !miss;
        fetch_busy = state == WAIT;
    end

    always_ff @(posedge clk, posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ext.ext_req  <= 1'b0;
            ext.ext_addr <= 16'd0;
            hit_addr     <= 16'd0;
            hit_data     <= 16'd0;
            hit_vld      <= 1'b0;
            last_exm     <= 1'b0;
            stall_cnt    <= '0;
        end else if (cen) begin
            last_exm <= ext_mode;
            if (!cpu_cen && stall_cnt != STALL_MAX) begin
                stall_cnt <= stall_cnt + SCW'(1);
            end
            case (state)
                IDLE: begin
                    if (exm_chg) begin
                        hit_vld <= 1'b0;
                    end
                    if (miss) begin
                        ext.ext_addr <= rom_addr;
                        ext.ext_req  <= 1'b1;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    // A mode change seen on the completing cycle still stores the word but invalidates it.
                    if (ext.ext_ok) begin
                        hit_data    <= ext.ext_data;
                        hit_addr    <= ext.ext_addr;
                        hit_vld     <= !exm_chg;
                        ext.ext_req <= 1'b0;
                        state       <= IDLE;
                    end else if (exm_chg) begin
                        hit_vld <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtdsp16_rom_fetch.sv
// Randomised and directed bench for jtdsp16_rom_fetch against a cycle-level behavioural model.
module tb_jtdsp16_rom_fetch;

    localparam int unsigned INT_AW = 12;
    localparam int unsigned SCW    = 5;
    localparam int unsigned SMAX   = (1 << SCW) - 1;

    logic              rst;
    logic              clk;
    logic              cen;
    logic              ext_mode;
    logic [15:0]       rom_addr;
    logic [15:0]       int_dout;
    logic [INT_AW-1:0] int_addr;
    logic [15:0]       rom_dout;
    logic              cpu_cen;
    logic              fetch_busy;
    logic [SCW-1:0]    stall_cnt;

    jtdsp16_rom_fetch_if ext ();

    jtdsp16_rom_fetch #(.INT_AW(INT_AW), .SCW(SCW)) dut (
        .rst        (rst),
        .clk        (clk),
        .cen        (cen),
        .ext_mode   (ext_mode),
        .rom_addr   (rom_addr),
        .int_addr   (int_addr),
        .int_dout   (int_dout),
        .ext        (ext.master),
        .rom_dout   (rom_dout),
        .cpu_cen    (cpu_cen),
        .fetch_busy (fetch_busy),
        .stall_cnt  (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: outstanding request, one cached external word, mode history, stall count.
    logic        m_wait = 1'b0;
    logic [15:0] m_ea   = 16'd0;
    logic        m_hv   = 1'b0;
    logic [15:0] m_ha   = 16'd0;
    logic [15:0] m_hd   = 16'd0;
    logic        m_last = 1'b0;
    int unsigned m_stall = 0;
    logic        m_cpu_prev = 1'b1;

    // Observed values from the latest cycle and per-test tallies.
    logic        s_cpu;
    logic        s_req;
    logic [15:0] s_dout;
    logic [15:0] s_eaddr;
    int unsigned s_stall;
    int          n_req = 0;
    int          n_low = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_wait  = 1'b0;
        m_ea    = 16'd0;
        m_hv    = 1'b0;
        m_ha    = 16'd0;
        m_hd    = 16'd0;
        m_last  = 1'b0;
        m_stall = 0;
    endtask

    // Called at edge+1: pulse reset, check the asynchronous clear, release at the next edge+1.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_ext_req", 32'(ext.ext_req), 32'd0);
        chk("rst_busy", 32'(fetch_busy), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        chk("rst_ext_addr", 32'(ext.ext_addr), 32'd0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock: drive inputs, compare all outputs against the model, then advance the model.
    task automatic cycle(input logic c, input logic e, input logic [15:0] a,
                         input logic ok, input logic [15:0] d, input logic [15:0] id);
        logic sel, hitm, miss, xcpu, chg;
        cen = c; ext_mode = e; rom_addr = a;
        ext.ext_ok = ok; ext.ext_data = d; int_dout = id;
        #2;
        sel  = e || (a >= 16'(1 << INT_AW));
        hitm = m_hv && (m_ha == a);
        miss = sel && !hitm;
        xcpu = c && !m_wait && !miss;
        chk("cpu_cen", 32'(cpu_cen), 32'(xcpu));
        chk("int_addr", 32'(int_addr), 32'(a[INT_AW-1:0]));
        chk("ext_req", 32'(ext.ext_req), 32'(m_wait));
        chk("fetch_busy", 32'(fetch_busy), 32'(m_wait));
        chk("ext_addr", 32'(ext.ext_addr), 32'(m_ea));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        if (xcpu) chk("rom_dout", 32'(rom_dout), 32'(sel ? m_hd : id));
        s_cpu = cpu_cen; s_req = ext.ext_req; s_dout = rom_dout;
        s_eaddr = ext.ext_addr; s_stall = 32'(stall_cnt);
        if (ext.ext_req) n_req++;
        if (!cpu_cen) n_low++;
        m_cpu_prev = xcpu;
        @(posedge clk);
        if (c) begin
            if (!xcpu && m_stall != SMAX) m_stall++;
            chg = e != m_last;
            m_last = e;
            if (!m_wait) begin
                if (chg) m_hv = 1'b0;
                if (miss) begin
                    m_wait = 1'b1;
                    m_ea   = a;
                end
            end else if (ok) begin
                m_hd   = d;
                m_ha   = m_ea;
                m_hv   = !chg;
                m_wait = 1'b0;
            end else if (chg) begin
                m_hv = 1'b0;
            end
        end
        #1;
    endtask

    logic [15:0] pool [4] = '{16'h1234, 16'h2000, 16'hF00F, 16'h1000};

    initial begin
        logic [15:0] a;
        logic        e;
        int          lat;
        rst = 1'b0; cen = 1'b0; ext_mode = 1'b0; rom_addr = 16'd0; int_dout = 16'd0;
        ext.ext_ok = 1'b0; ext.ext_data = 16'd0;
        #1;
        do_reset();

        // Sequential internal fetches never stall or request.
        n_req = 0; n_low = 0;
        for (int i = 0; i < 4096; i++) cycle(1'b1, 1'b0, 16'(i), 1'b0, 16'($urandom), 16'($urandom));
        chk("t1_req_cycles", 32'(n_req), 32'd0);
        chk("t1_stall_cycles", 32'(n_low), 32'd0);

        // External miss, ok three cycles after the request rises.
        n_req = 0; n_low = 0;
        cycle(1'b1, 1'b0, 16'h1234, 1'b0, 16'h0000, 16'h1111);
        cycle(1'b1, 1'b0, 16'h1234, 1'b0, 16'h0000, 16'h1111);
        chk("t2_ext_addr", 32'(s_eaddr), 32'h1234);
        cycle(1'b1, 1'b0, 16'h1234, 1'b0, 16'h0000, 16'h1111);
        cycle(1'b1, 1'b0, 16'h1234, 1'b1, 16'hBEEF, 16'h1111);
        cycle(1'b1, 1'b0, 16'h1234, 1'b0, 16'h0000, 16'h1111);
        chk("t2_req_cycles", 32'(n_req), 32'd3);
        chk("t2_low_cycles", 32'(n_low), 32'd4);
        chk("t2_dout", 32'(s_dout), 32'hBEEF);
        chk("t2_stall", s_stall, 32'd4);

        // pc_halt on the same external address: served from the hit register.
        n_req = 0; n_low = 0;
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 16'h1234, 1'b0, 16'h0, 16'h2222);
        chk("t3_req_cycles", 32'(n_req), 32'd0);
        chk("t3_low_cycles", 32'(n_low), 32'd0);
        chk("t3_stall", s_stall, 32'd4);

        // ext_mode 0->1 forces an external fetch of 0x0010; 1->0 returns to internal ROM.
        cycle(1'b1, 1'b0, 16'h0010, 1'b0, 16'h0, 16'h3333);
        chk("t4_int_dout", 32'(s_dout), 32'h3333);
        cycle(1'b1, 1'b1, 16'h0010, 1'b0, 16'h0, 16'h3333);
        chk("t4_miss", 32'(s_cpu), 32'd0);
        cycle(1'b1, 1'b1, 16'h0010, 1'b1, 16'h5A5A, 16'h3333);
        chk("t4_ext_addr", 32'(s_eaddr), 32'h0010);
        cycle(1'b1, 1'b1, 16'h0010, 1'b0, 16'h0, 16'h3333);
        chk("t4_ext_dout", 32'(s_dout), 32'h5A5A);
        cycle(1'b1, 1'b0, 16'h0010, 1'b0, 16'h0, 16'h7777);
        chk("t4_back_int", 32'(s_dout), 32'h7777);
        chk("t4_back_cpu", 32'(s_cpu), 32'd1);

        // Miss with cen active one cycle in three.
        do_reset();
        cycle(1'b1, 1'b0, 16'h3000, 1'b0, 16'h0, 16'h0);
        cycle(1'b0, 1'b0, 16'h3000, 1'b0, 16'h0, 16'h0);
        cycle(1'b0, 1'b0, 16'h3000, 1'b0, 16'h0, 16'h0);
        cycle(1'b1, 1'b0, 16'h3000, 1'b1, 16'h4242, 16'h0);
        cycle(1'b0, 1'b0, 16'h3000, 1'b0, 16'h0, 16'h0);
        cycle(1'b0, 1'b0, 16'h3000, 1'b0, 16'h0, 16'h0);
        cycle(1'b1, 1'b0, 16'h3000, 1'b0, 16'h0, 16'h0);
        chk("t6_cpu", 32'(s_cpu), 32'd1);
        chk("t6_dout", 32'(s_dout), 32'h4242);
        chk("t6_stall", s_stall, 32'd2);

        // Reset during an outstanding request; a late ok is not captured.
        cycle(1'b1, 1'b0, 16'h2000, 1'b0, 16'h0, 16'h0);
        cycle(1'b1, 1'b0, 16'h2000, 1'b0, 16'h0, 16'h0);
        chk("t5_req_before", 32'(s_req), 32'd1);
        do_reset();
        cycle(1'b1, 1'b0, 16'h2000, 1'b1, 16'hDEAD, 16'h0);
        chk("t5_no_hit", 32'(s_cpu), 32'd0);
        cycle(1'b1, 1'b0, 16'h2000, 1'b1, 16'h1111, 16'h0);
        cycle(1'b1, 1'b0, 16'h2000, 1'b0, 16'h0, 16'h0);
        chk("t5_dout", 32'(s_dout), 32'h1111);

        // Long wait drives the stall counter into saturation.
        do_reset();
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 16'h8000, 1'b0, 16'h0, 16'h0);
        chk("sat_stall", s_stall, SMAX);
        cycle(1'b1, 1'b1, 16'h8000, 1'b1, 16'h6060, 16'h0);
        cycle(1'b1, 1'b1, 16'h8000, 1'b0, 16'h0, 16'h0);
        chk("sat_hold", s_stall, SMAX);

        // Random traffic with a latency-varying external responder.
        do_reset();
        a = 16'd0; e = 1'b0; lat = 0;
        for (int i = 0; i < 3000; i++) begin
            logic c, ok;
            c = $urandom_range(0, 9) < 7;
            if (m_cpu_prev) begin
                case ($urandom_range(0, 5))
                    0, 1:    a = a;
                    2:       a = 16'($urandom_range(0, 4095));
                    3:       a = pool[$urandom_range(0, 3)];
                    4:       a = a + 16'd1;
                    default: a = 16'($urandom_range(0, 65535));
                endcase
            end
            if ($urandom_range(0, 29) == 0) e = !e;
            if (!m_wait) begin
                ok  = $urandom_range(0, 19) == 0;
                lat = $urandom_range(0, 3);
            end else if (lat > 0) begin
                ok = 1'b0;
                lat--;
            end else begin
                ok = 1'b1;
            end
            cycle(c, e, a, ok, 16'($urandom), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
